// File: rtl/pipe_ctrl_pkg.sv
// Shared types and mcause constants for the pipeline sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    StRun,
    StLoadStall,
    StTrapEnter,
    StMretRet,
    StMemWait
  } state_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_MTVEC  = 2'd2,
    PC_MEPC   = 2'd3
  } pc_sel_e;

  localparam int unsigned CAUSE_ILLEGAL    = 2;
  localparam int unsigned CAUSE_LOAD_FAULT = 5;
  localparam int unsigned CAUSE_ECALL_M    = 11;
  localparam int unsigned INTERRUPT_BIT    = 31;

  // Illegal takes precedence over ecall when both decode in the same instruction.
  function automatic int unsigned exc_cause(input logic illegal);
    return illegal ? CAUSE_ILLEGAL : CAUSE_ECALL_M;
  endfunction

endpackage

// File: rtl/pipe_ctrl_fsm_if.sv
// Request/control bundle between the pipeline sequencer and the core datapath/CSR file.
interface pipe_ctrl_fsm_if #(
  parameter int unsigned XLEN = 32
);
  logic            valid_DE_i;
  logic            hz_stall_i;
  logic            br_taken_i;
  logic            illegal_i;
  logic            ecall_i;
  logic            mret_i;
  logic            irq_pending_i;
  logic [3:0]      irq_cause_i;
  logic            mem_busy_i;
  logic [XLEN-1:0] pc_DE_i;

  logic            stall_F_o;
  logic            stall_DE_o;
  logic            flush_F_o;
  logic            flush_MW_o;
  logic [1:0]      pc_sel_o;
  logic            trap_take_o;
  logic            mret_take_o;
  logic [XLEN-1:0] epc_o;
  logic [XLEN-1:0] cause_o;
  logic            busy_o;

  // Sequencer side.
  modport master (
    input  valid_DE_i, hz_stall_i, br_taken_i, illegal_i, ecall_i, mret_i,
    input  irq_pending_i, irq_cause_i, mem_busy_i, pc_DE_i,
    output stall_F_o, stall_DE_o, flush_F_o, flush_MW_o, pc_sel_o,
    output trap_take_o, mret_take_o, epc_o, cause_o, busy_o
  );

  // Datapath / CSR side.
  modport slave (
    output valid_DE_i, hz_stall_i, br_taken_i, illegal_i, ecall_i, mret_i,
    output irq_pending_i, irq_cause_i, mem_busy_i, pc_DE_i,
    input  stall_F_o, stall_DE_o, flush_F_o, flush_MW_o, pc_sel_o,
    input  trap_take_o, mret_take_o, epc_o, cause_o, busy_o
  );
endinterface

// File: rtl/pipe_ctrl_fsm_mem_timeout_ctr.sv
// Saturating count of consecutive memory-busy cycles; o_hit flags the timeout value.
module mem_timeout_ctr #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);
  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MEM_TIMEOUT);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != MaxCnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_hit = (r_cnt == MaxCnt);

endmodule

// File: rtl/pipe_ctrl_fsm.sv
// Pipeline sequencer: arbitrates DE-stage events and drives stall/flush/PC-select/CSR pulses.
module pipe_ctrl_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned XLEN        = 32
) (
  input logic             clk,
  input logic             rst,
  pipe_ctrl_fsm_if.master bus
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] w_epc_nxt;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] w_cause_nxt;

  logic    w_stall_f;
  logic    w_stall_de;
  logic    w_flush_f;
  logic    w_flush_mw;
  pc_sel_e w_pc_sel;
  logic    w_trap_take;
  logic    w_mret_take;

  logic w_cnt_en;
  logic w_cnt_clr;
  logic w_cnt_hit;

  logic w_exc;
  logic w_mret;
  logic w_irq;
  logic w_br;
  logic w_hz;

  assign w_exc  = bus.valid_DE_i & (bus.illegal_i | bus.ecall_i);
  assign w_mret = bus.valid_DE_i & bus.mret_i;
  assign w_irq  = bus.valid_DE_i & bus.irq_pending_i;
  assign w_br   = bus.valid_DE_i & bus.br_taken_i;
  assign w_hz   = bus.valid_DE_i & bus.hz_stall_i;

  always_comb begin
    w_state_nxt = r_state;
    w_epc_nxt   = r_epc;
    w_cause_nxt = r_cause;
    w_stall_f   = 1'b0;
    w_stall_de  = 1'b0;
    w_flush_f   = 1'b0;
    w_flush_mw  = 1'b0;
    w_pc_sel    = PC_PLUS4;
    w_trap_take = 1'b0;
    w_mret_take = 1'b0;
    w_cnt_en    = 1'b0;

    unique case (r_state)
      StRun: begin
        if (bus.mem_busy_i) begin
          w_stall_f   = 1'b1;
          w_stall_de  = 1'b1;
          w_cnt_en    = 1'b1;
          w_state_nxt = StMemWait;
        end else if (w_exc) begin
          w_flush_f   = 1'b1;
          w_flush_mw  = 1'b1;
          w_epc_nxt   = bus.pc_DE_i;
          w_cause_nxt = XLEN'(exc_cause(bus.illegal_i));
          w_state_nxt = StTrapEnter;
        end else if (w_mret) begin
          w_flush_f   = 1'b1;
          w_flush_mw  = 1'b1;
          w_state_nxt = StMretRet;
        end else if (w_irq) begin
          // DE instruction is killed, so mepc points at it for re-execution.
          w_flush_f                  = 1'b1;
          w_flush_mw                 = 1'b1;
          w_epc_nxt                  = bus.pc_DE_i;
          w_cause_nxt                = '0;
          w_cause_nxt[INTERRUPT_BIT] = 1'b1;
          w_cause_nxt[3:0]           = bus.irq_cause_i;
          w_state_nxt                = StTrapEnter;
        end else if (w_br) begin
          w_pc_sel  = PC_BRANCH;
          w_flush_f = 1'b1;
        end else if (w_hz) begin
          w_stall_f   = 1'b1;
          w_flush_mw  = 1'b1;
          w_state_nxt = StLoadStall;
        end
      end

      StLoadStall: begin
        // Hazard requests are ignored here so the stalled load always drains.
        w_state_nxt = StRun;
        if (w_br) begin
          w_pc_sel  = PC_BRANCH;
          w_flush_f = 1'b1;
        end
      end

      StTrapEnter: begin
        w_trap_take = 1'b1;
        w_pc_sel    = PC_MTVEC;
        w_flush_f   = 1'b1;
        w_state_nxt = StRun;
      end

      StMretRet: begin
        w_mret_take = 1'b1;
        w_pc_sel    = PC_MEPC;
        w_flush_f   = 1'b1;
        w_state_nxt = StRun;
      end

      StMemWait: begin
        if (!bus.mem_busy_i) begin
          w_state_nxt = StRun;
        end else if (w_cnt_hit) begin
          w_flush_f   = 1'b1;
          w_flush_mw  = 1'b1;
          w_epc_nxt   = bus.pc_DE_i;
          w_cause_nxt = XLEN'(CAUSE_LOAD_FAULT);
          w_state_nxt = StTrapEnter;
        end else begin
          w_stall_f  = 1'b1;
          w_stall_de = 1'b1;
          w_cnt_en   = 1'b1;
        end
      end

      default: w_state_nxt = StRun;
    endcase
  end

  // Counter is only live while stalling on memory; any other cycle returns it to zero.
  assign w_cnt_clr = ~w_cnt_en;

  mem_timeout_ctr #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_timeout_ctr (
    .clk  (clk),
    .rst  (rst),
    .i_clr(w_cnt_clr),
    .i_en (w_cnt_en),
    .o_hit(w_cnt_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StRun;
      r_epc   <= '0;
      r_cause <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_epc   <= w_epc_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  // Controls are forced idle during reset so no pulse survives into it.
  assign bus.stall_F_o   = w_stall_f & ~rst;
  assign bus.stall_DE_o  = w_stall_de & ~rst;
  assign bus.flush_F_o   = w_flush_f & ~rst;
  assign bus.flush_MW_o  = w_flush_mw & ~rst;
  assign bus.pc_sel_o    = rst ? PC_PLUS4 : w_pc_sel;
  assign bus.trap_take_o = w_trap_take & ~rst;
  assign bus.mret_take_o = w_mret_take & ~rst;
  assign bus.epc_o       = r_epc;
  assign bus.cause_o     = r_cause;
  assign bus.busy_o      = (r_state != StRun) & ~rst;

endmodule

// File: tb/tb_pipe_ctrl_fsm.sv
// Directed bench for pipe_ctrl_fsm with hand-computed expected values.
module tb_pipe_ctrl_fsm;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  pipe_ctrl_fsm_if #(.XLEN(32)) bus ();

  pipe_ctrl_fsm #(
    .MEM_TIMEOUT(16),
    .XLEN       (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.valid_DE_i    = 1'b0;
    bus.hz_stall_i    = 1'b0;
    bus.br_taken_i    = 1'b0;
    bus.illegal_i     = 1'b0;
    bus.ecall_i       = 1'b0;
    bus.mret_i        = 1'b0;
    bus.irq_pending_i = 1'b0;
    bus.irq_cause_i   = 4'd0;
    bus.mem_busy_i    = 1'b0;
    bus.pc_DE_i       = 32'h0;
  endtask

  initial begin
    // Reset with live requests: everything must stay quiet.
    idle();
    rst = 1'b1;
    bus.valid_DE_i = 1'b1;
    bus.hz_stall_i = 1'b1;
    bus.br_taken_i = 1'b1;
    #2;
    chk("rst_stall_f", 32'(bus.stall_F_o), 32'd0);
    chk("rst_flush_f", 32'(bus.flush_F_o), 32'd0);
    chk("rst_pc_sel", 32'(bus.pc_sel_o), 32'd0);
    cyc();
    chk("rst_epc", bus.epc_o, 32'h0);
    chk("rst_cause", bus.cause_o, 32'h0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    rst = 1'b0;
    idle();
    #2;
    chk("post_rst_stall", 32'(bus.stall_F_o), 32'd0);
    chk("post_rst_busy", 32'(bus.busy_o), 32'd0);
    cyc();

    // Load-use hazard held three cycles: bubble, free cycle, bubble again.
    bus.valid_DE_i = 1'b1;
    bus.hz_stall_i = 1'b1;
    #2;
    chk("hz0_stall_f", 32'(bus.stall_F_o), 32'd1);
    chk("hz0_flush_mw", 32'(bus.flush_MW_o), 32'd1);
    chk("hz0_stall_de", 32'(bus.stall_DE_o), 32'd0);
    cyc();
    #2;
    chk("hz1_stall_f", 32'(bus.stall_F_o), 32'd0);
    chk("hz1_flush_mw", 32'(bus.flush_MW_o), 32'd0);
    chk("hz1_busy", 32'(bus.busy_o), 32'd1);
    cyc();
    #2;
    chk("hz2_stall_f", 32'(bus.stall_F_o), 32'd1);
    chk("hz2_flush_mw", 32'(bus.flush_MW_o), 32'd1);
    cyc();
    // LOAD_STALL still honours a taken branch.
    bus.hz_stall_i = 1'b0;
    bus.br_taken_i = 1'b1;
    #2;
    chk("ls_br_pc_sel", 32'(bus.pc_sel_o), 32'd1);
    chk("ls_br_flush_f", 32'(bus.flush_F_o), 32'd1);
    chk("ls_br_stall_f", 32'(bus.stall_F_o), 32'd0);
    cyc();

    // Plain branch in RUN.
    #2;
    chk("br_pc_sel", 32'(bus.pc_sel_o), 32'd1);
    chk("br_flush_f", 32'(bus.flush_F_o), 32'd1);
    chk("br_flush_mw", 32'(bus.flush_MW_o), 32'd0);
    chk("br_busy", 32'(bus.busy_o), 32'd0);
    cyc();

    // Illegal + branch: the trap wins.
    bus.illegal_i = 1'b1;
    bus.pc_DE_i   = 32'h100;
    #2;
    chk("ill_flush_f", 32'(bus.flush_F_o), 32'd1);
    chk("ill_flush_mw", 32'(bus.flush_MW_o), 32'd1);
    chk("ill_pc_sel", 32'(bus.pc_sel_o), 32'd0);
    cyc();
    idle();
    #2;
    chk("ill_trap_take", 32'(bus.trap_take_o), 32'd1);
    chk("ill_pc_sel_mtvec", 32'(bus.pc_sel_o), 32'd2);
    chk("ill_te_flush_f", 32'(bus.flush_F_o), 32'd1);
    chk("ill_epc", bus.epc_o, 32'h100);
    chk("ill_cause", bus.cause_o, 32'd2);
    chk("ill_te_busy", 32'(bus.busy_o), 32'd1);
    cyc();
    #2;
    chk("ill_trap_done", 32'(bus.trap_take_o), 32'd0);
    chk("ill_busy_done", 32'(bus.busy_o), 32'd0);

    // ecall alone.
    bus.valid_DE_i = 1'b1;
    bus.ecall_i    = 1'b1;
    bus.pc_DE_i    = 32'h104;
    cyc();
    idle();
    #2;
    chk("ecall_trap_take", 32'(bus.trap_take_o), 32'd1);
    chk("ecall_cause", bus.cause_o, 32'd11);
    chk("ecall_epc", bus.epc_o, 32'h104);
    cyc();

    // Interrupt pending while memory is busy for three cycles.
    bus.valid_DE_i    = 1'b1;
    bus.irq_pending_i = 1'b1;
    bus.irq_cause_i   = 4'd11;
    bus.mem_busy_i    = 1'b1;
    bus.pc_DE_i       = 32'h300;
    #2;
    chk("irqmb0_stall_f", 32'(bus.stall_F_o), 32'd1);
    chk("irqmb0_stall_de", 32'(bus.stall_DE_o), 32'd1);
    chk("irqmb0_flush_mw", 32'(bus.flush_MW_o), 32'd0);
    cyc();
    #2;
    chk("irqmb1_stall_de", 32'(bus.stall_DE_o), 32'd1);
    chk("irqmb1_trap", 32'(bus.trap_take_o), 32'd0);
    cyc();
    #2;
    chk("irqmb2_stall_f", 32'(bus.stall_F_o), 32'd1);
    cyc();
    bus.mem_busy_i = 1'b0;
    #2;
    chk("irqmb3_stall_f", 32'(bus.stall_F_o), 32'd0);
    chk("irqmb3_flush_f", 32'(bus.flush_F_o), 32'd0);
    chk("irqmb3_busy", 32'(bus.busy_o), 32'd1);
    cyc();
    #2;
    chk("irq_flush_f", 32'(bus.flush_F_o), 32'd1);
    chk("irq_flush_mw", 32'(bus.flush_MW_o), 32'd1);
    cyc();
    idle();
    #2;
    chk("irq_trap_take", 32'(bus.trap_take_o), 32'd1);
    chk("irq_cause", bus.cause_o, 32'h8000_000B);
    chk("irq_epc", bus.epc_o, 32'h300);
    cyc();

    // mret.
    bus.valid_DE_i = 1'b1;
    bus.mret_i     = 1'b1;
    bus.pc_DE_i    = 32'h200;
    #2;
    chk("mret_flush_f", 32'(bus.flush_F_o), 32'd1);
    chk("mret_flush_mw", 32'(bus.flush_MW_o), 32'd1);
    cyc();
    idle();
    #2;
    chk("mret_take", 32'(bus.mret_take_o), 32'd1);
    chk("mret_pc_sel", 32'(bus.pc_sel_o), 32'd3);
    chk("mret_trap_take", 32'(bus.trap_take_o), 32'd0);
    chk("mret_epc_kept", bus.epc_o, 32'h300);
    cyc();
    #2;
    chk("mret_take_done", 32'(bus.mret_take_o), 32'd0);

    // Memory timeout: 16 stall cycles, then flush and access-fault trap.
    bus.mem_busy_i = 1'b1;
    bus.pc_DE_i    = 32'h400;
    for (int i = 0; i < 16; i++) begin
      #2;
      chk($sformatf("mto_stall_%0d", i),
          {29'd0, bus.stall_F_o, bus.stall_DE_o, bus.flush_MW_o}, 32'b110);
      cyc();
    end
    #2;
    chk("mto_stall_f", 32'(bus.stall_F_o), 32'd0);
    chk("mto_flush_f", 32'(bus.flush_F_o), 32'd1);
    chk("mto_flush_mw", 32'(bus.flush_MW_o), 32'd1);
    cyc();
    bus.mem_busy_i = 1'b0;
    #2;
    chk("mto_trap_take", 32'(bus.trap_take_o), 32'd1);
    chk("mto_cause", bus.cause_o, 32'd5);
    chk("mto_epc", bus.epc_o, 32'h400);
    cyc();

    // Reset while in TRAP_ENTER.
    bus.valid_DE_i = 1'b1;
    bus.illegal_i  = 1'b1;
    bus.pc_DE_i    = 32'h500;
    cyc();
    idle();
    rst = 1'b1;
    #2;
    chk("rte_trap_in_rst", 32'(bus.trap_take_o), 32'd0);
    chk("rte_pc_sel_in_rst", 32'(bus.pc_sel_o), 32'd0);
    cyc();
    rst = 1'b0;
    #2;
    chk("rte_trap_after", 32'(bus.trap_take_o), 32'd0);
    chk("rte_busy_after", 32'(bus.busy_o), 32'd0);
    chk("rte_epc_after", bus.epc_o, 32'h0);
    chk("rte_cause_after", bus.cause_o, 32'h0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
